// File: rtl/ctrl_pkg.sv
// Shared opcode, ALUOp and FSM state definitions for the multi-cycle CPU
// control path.
package ctrl_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT};
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Opcode/handshake inputs and control strobes between the control unit
// (master) and the datapath (slave).
interface multicycle_control_unit_if;
  logic [3:0]  Opcode;
  logic        MemReady;
  logic        RegDst;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemToReg;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        IRWrite;
  logic        PCWrite;
  logic        Illegal;
  logic        Fault;
  logic        Halted;
  logic [15:0] InstrCount;

  modport master (
    input  Opcode, MemReady,
    output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, IRWrite, PCWrite, Illegal, Fault, Halted, InstrCount
  );

  modport slave (
    output Opcode, MemReady,
    input  RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, IRWrite, PCWrite, Illegal, Fault, Halted, InstrCount
  );
endinterface

// File: rtl/cu_mem_watchdog.sv
// Counts consecutive not-ready MEM cycles; expire fires in the last allowed
// cycle unless ready arrives in that same cycle.
module cu_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = enable && !ready && (cnt_q == LAST);

  // Next count: advance only on waiting MEM cycles, otherwise restart.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || ready || expire) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB strobes,
// handles illegal/halt opcodes, MEM watchdog and retired-instruction count.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 8,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input logic                        Clock,
  input logic                        Reset,
  multicycle_control_unit_if.master  bus
);

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        fault_q, fault_d;
  logic [15:0] count_q, count_d;
  logic        wd_expire;
  logic        dec_legal;

  assign dec_legal = op_is_legal(bus.Opcode);

  cu_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk    (Clock),
    .rst    (Reset),
    .enable (state_q == ST_MEM),
    .clear  (state_q == ST_EXEC),
    .ready  (bus.MemReady),
    .expire (wd_expire)
  );

  // Moore strobe decode; DECODE looks at the live Opcode because opcode_q
  // is only written at the end of that cycle, and the SW retire pulse in MEM
  // is qualified by MemReady so the store retires in its completion cycle.
  always_comb begin
    bus.RegDst   = 1'b0;
    bus.Branch   = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemToReg = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = ALUOP_ADD;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.Illegal  = 1'b0;
    bus.Halted   = 1'b0;
    unique case (state_q)
      ST_FETCH: bus.IRWrite = 1'b1;
      ST_DECODE: begin
        if (!dec_legal) begin
          bus.Illegal = 1'b1;
          bus.PCWrite = !ILLEGAL_HALT;
        end
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_R:    bus.ALUOp = ALUOP_RTYPE;
          OP_ADDI: begin bus.ALUOp = ALUOP_ITYPE; bus.ALUSrc = 1'b1; end
          OP_LW, OP_SW: bus.ALUSrc = 1'b1;
          OP_BEQ: begin
            bus.ALUOp   = ALUOP_SUB;
            bus.Branch  = 1'b1;
            bus.PCWrite = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.ALUSrc   = 1'b1;
        bus.MemRead  = (opcode_q == OP_LW);
        bus.MemWrite = (opcode_q == OP_SW);
        bus.PCWrite  = (opcode_q == OP_SW) && bus.MemReady;
      end
      ST_WB: begin
        bus.RegWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.RegDst   = (opcode_q == OP_R);
        bus.MemToReg = (opcode_q == OP_LW);
      end
      ST_HALT: bus.Halted = 1'b1;
      default: ;
    endcase
    bus.Fault      = fault_q;
    bus.InstrCount = count_q;
  end

  // Next-state, opcode latch, sticky fault and retire counter.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    fault_d  = fault_q;
    count_d  = count_q;
    unique case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = bus.Opcode;
        if (bus.Opcode == OP_HALT) state_d = ST_HALT;
        else if (!dec_legal) begin
          if (ILLEGAL_HALT) state_d = ST_HALT;
          else              state_d = ST_FETCH;
        end
        else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode_q)
          OP_LW, OP_SW: state_d = ST_MEM;
          OP_BEQ:       state_d = ST_FETCH;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.MemReady) begin
          if (opcode_q == OP_LW) state_d = ST_WB;
          else                   state_d = ST_FETCH;
        end
        else if (wd_expire) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
    if (bus.PCWrite) count_d = count_q + 16'd1;
  end

  // State registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_RST;
      opcode_q <= '0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

endmodule
